seq_alu: RTL and testbench

//  Registered, handshaked successor of the combinational ALU: WIDTH-parametrised datapath, rotate by variable

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_mul_seq.sv | 52 +++++
 rtl/seq_alu.sv | 134 +++++++++++++
 tb/tb_seq_alu.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD       = 4'd1;
  localparam logic [3:0] OP_ADD_CARRY = 4'd2;
  localparam logic [3:0] OP_SUB       = 4'd3;
  localparam logic [3:0] OP_INC       = 4'd4;
  localparam logic [3:0] OP_DEC       = 4'd5;
  localparam logic [3:0] OP_AND       = 4'd6;
  localparam logic [3:0] OP_NOT       = 4'd7;
  localparam logic [3:0] OP_ROL       = 4'd8;
  localparam logic [3:0] OP_ROR       = 4'd9;
  localparam logic [3:0] OP_OR        = 4'd10;
  localparam logic [3:0] OP_XOR       = 4'd11;
  localparam logic [3:0] OP_MUL       = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per cycle, BUS_WIDTH cycles per start.
module alu_mul_seq #(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [BUS_WIDTH-1:0]   a_i,
  input  logic [BUS_WIDTH-1:0]   b_i,
  output logic                   done_o,
  output logic [2*BUS_WIDTH-1:0] product_o
);

  localparam int unsigned CW = $clog2(BUS_WIDTH + 1);

  logic                   busy_q;
  logic [CW-1:0]          cnt_q;
  logic [2*BUS_WIDTH-1:0] acc_q, acc_d;
  logic [2*BUS_WIDTH-1:0] mcand_q;
  logic [BUS_WIDTH-1:0]   mplier_q;

  // The final partial sum is exposed combinationally so the parent can latch it
  // on the same edge that retires the last iteration.
  always_comb begin
    acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    done_o    = busy_q && (cnt_q == CW'(1));
    product_o = acc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CW'(BUS_WIDTH);
      acc_q    <= '0;
      mcand_q  <= {{BUS_WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered, valid/ready-handshaked ALU; single-cycle ops complete on accept, MUL uses alu_mul_seq.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] y,
  output logic [BUS_WIDTH-1:0] y_hi,
  output logic                 carry_out,
  output logic                 borrow,
  output logic                 zero,
  output logic                 parity,
  output logic                 invalid_op
);

  localparam int unsigned W   = BUS_WIDTH;
  localparam int unsigned SHW = $clog2(BUS_WIDTH);

  alu_state_e     state_q, state_d;
  logic [W-1:0]   y_q, y_hi_q;
  logic           carry_q, borrow_q, zero_q, parity_q, inv_q;

  logic           accept, is_mul, mul_start, mul_done;
  logic [2*W-1:0] mul_prod;
  logic [W-1:0]   res_y;
  logic           res_c, res_bw, res_inv;
  logic [W:0]     wide;
  logic [2*W-1:0] rot;
  logic [SHW-1:0] rot_amt;

  alu_mul_seq #(.BUS_WIDTH(W)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Rotates take the upper/lower half of {a,a} shifted, so amount 0 returns a unchanged.
  always_comb begin
    res_y   = '0;
    res_c   = 1'b0;
    res_bw  = 1'b0;
    res_inv = 1'b0;
    wide    = '0;
    rot     = '0;
    rot_amt = SHW'(32'(b[SHW-1:0]) % BUS_WIDTH);
    case (opcode)
      OP_ADD:       begin wide = {1'b0, a} + {1'b0, b};                      res_y = wide[W-1:0]; res_c  = wide[W]; end
      OP_ADD_CARRY: begin wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in}; res_y = wide[W-1:0]; res_c  = wide[W]; end
      OP_INC:       begin wide = {1'b0, a} + (W+1)'(1);                      res_y = wide[W-1:0]; res_c  = wide[W]; end
      OP_SUB:       begin wide = {1'b0, a} - {1'b0, b};                      res_y = wide[W-1:0]; res_bw = wide[W]; end
      OP_DEC:       begin wide = {1'b0, a} - (W+1)'(1);                      res_y = wide[W-1:0]; res_bw = wide[W]; end
      OP_AND:       res_y = a & b;
      OP_NOT:       res_y = ~a;
      OP_OR:        res_y = a | b;
      OP_XOR:       res_y = a ^ b;
      OP_ROL:       begin rot = {a, a} << rot_amt; res_y = rot[2*W-1:W]; end
      OP_ROR:       begin rot = {a, a} >> rot_amt; res_y = rot[W-1:0];   end
      OP_MUL:       res_y = '0;
      default:      res_inv = 1'b1;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    accept    = in_valid && in_ready;
    is_mul    = (opcode == OP_MUL);
    mul_start = accept && is_mul;
    state_d   = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept)                 state_d = is_mul ? ST_BUSY : ST_DONE;
        else if (state_q == ST_DONE && out_ready) state_d = ST_IDLE;
      end
      ST_BUSY: if (mul_done) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      y_q      <= '0;
      y_hi_q   <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && !is_mul) begin
        y_q      <= res_y;
        y_hi_q   <= '0;
        carry_q  <= res_c;
        borrow_q <= res_bw;
        zero_q   <= (res_y == '0);
        parity_q <= ^res_y;
        inv_q    <= res_inv;
      end else if (state_q == ST_BUSY && mul_done) begin
        y_q      <= mul_prod[W-1:0];
        y_hi_q   <= mul_prod[2*W-1:W];
        carry_q  <= |mul_prod[2*W-1:W];
        borrow_q <= 1'b0;
        zero_q   <= (mul_prod == '0);
        parity_q <= ^mul_prod[W-1:0];
        inv_q    <= 1'b0;
      end
    end
  end

  assign out_valid  = (state_q == ST_DONE);
  assign y          = y_q;
  assign y_hi       = y_hi_q;
  assign carry_out  = carry_q;
  assign borrow     = borrow_q;
  assign zero       = zero_q;
  assign parity     = parity_q;
  assign invalid_op = inv_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (BUS_WIDTH=8): vector table plus handshake/MUL/reset sequences.
module tb_seq_alu;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] a, b;
  logic         carry_in;
  logic         out_valid, out_ready;
  logic [W-1:0] y, y_hi;
  logic         carry_out, borrow, zero, parity, invalid_op;

  int checks = 0;
  int errors = 0;

  seq_alu #(.BUS_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .a          (a),
    .b          (b),
    .carry_in   (carry_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .y_hi       (y_hi),
    .carry_out  (carry_out),
    .borrow     (borrow),
    .zero       (zero),
    .parity     (parity),
    .invalid_op (invalid_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] y;
    logic       c, bw, z, p, inv;
  } vec_t;

  vec_t vecs[21];

  // {out_valid, in_ready, y, y_hi, carry, borrow, zero, parity, invalid}
  function automatic logic [22:0] pk(input logic v, input logic r, input logic [7:0] yy,
                                     input logic [7:0] hi, input logic c, input logic bw,
                                     input logic z, input logic p, input logic inv);
    return {v, r, yy, hi, c, bw, z, p, inv};
  endfunction

  function automatic logic [22:0] obs();
    return {out_valid, in_ready, y, y_hi, carry_out, borrow, zero, parity, invalid_op};
  endfunction

  task automatic chk(input string name, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] aa,
                       input logic [7:0] bb, input logic cin);
    in_valid = v;
    opcode   = op;
    a        = aa;
    b        = bb;
    carry_in = cin;
  endtask

  initial begin
    vecs[0]  = '{4'd2,  8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'd3,  8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'd5,  8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'd8,  8'h81, 8'h03, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'd9,  8'h81, 8'h09, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'd8,  8'h5A, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd1,  8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'd1,  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'd4,  8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4'd4,  8'h7F, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'd6,  8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd7,  8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'd10, 8'hA0, 8'h05, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'd11, 8'h55, 8'h54, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{4'd0,  8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{4'd13, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{4'd3,  8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{4'd9,  8'h01, 8'h07, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{4'd1,  8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{4'd5,  8'h01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{4'd2,  8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset", obs(), pk(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Back-to-back single-cycle ops with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      @(negedge clk);
      chk($sformatf("vec%0d", i), obs(),
          pk(1'b1, 1'b1, vecs[i].y, 8'h00, vecs[i].c, vecs[i].bw, vecs[i].z, vecs[i].p, vecs[i].inv));
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("drain_idle", {out_valid, in_ready}, {1'b1, 1'b1} & 2'b01);

    // MUL 0xFF*0xFF, operands changed after accept, out_ready low so in_ready stays low on completion
    out_ready = 1'b0;
    drive(1'b1, 4'd12, 8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd1, 8'h01, 8'h02, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("mul_busy%0d", k), {out_valid, in_ready}, 2'b00);
      @(negedge clk);
    end
    chk("mul_result", obs(), pk(1'b1, 1'b0, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("mul_consumed", {out_valid, in_ready}, 2'b01);

    // Result held under backpressure, then new pending op accepted on the releasing cycle
    out_ready = 1'b0;
    drive(1'b1, 4'd1, 8'h02, 8'h03, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd11, 8'h0F, 8'hFF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d", k), obs(), pk(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", {out_valid, in_ready}, 2'b11);
    @(negedge clk);
    chk("after_release", obs(), pk(1'b1, 1'b1, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);

    // Reset asserted during MUL: result discarded
    out_ready = 1'b0;
    drive(1'b1, 4'd12, 8'h0F, 8'h0F, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_mul", obs(), pk(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d", k), {out_valid, in_ready}, 2'b01);
    end
    out_ready = 1'b1;
    drive(1'b1, 4'd1, 8'h02, 8'h03, 1'b0);
    @(negedge clk);
    chk("post_rst_add", obs(), pk(1'b1, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
